// File: rtl/mul_share_arbiter.sv
// ============================================================================
// Module  : mul_share_arbiter
// Purpose : Round-robin sharing of one external combinational 4x4 multiplier
//           among NREQ requesters, returning product and owner ID.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mul_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_res,
  output logic              rsp_valid,
  output logic [7:0]        rsp_res,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     mul_a_q, mul_b_q;
  logic [7:0]     rsp_res_q;
  logic [IDW-1:0] rsp_id_q;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   scan_sum;

  // Search starts at rr_ptr and wraps modulo NREQ (NREQ need not be a power of 2)
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[scan_sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sum[IDW-1:0];
      end
    end
  end

  assign rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_found) state_d = S_MUL;
      S_MUL:   if (cnt_q == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant is gated by rst_n so no transfer can appear while reset is held
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found && rst_n) begin
          req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
        end
      end
      S_MUL: begin
        busy = 1'b1;
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      rsp_res_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            mul_a_q  <= req_a[{gnt_idx, 2'b00} +: 4];
            mul_b_q  <= req_b[{gnt_idx, 2'b00} +: 4];
            rsp_id_q <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= CW'(SETTLE-1);
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            rsp_res_q <= mul_res;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign rsp_res = rsp_res_q;
  assign rsp_id  = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter: directed transactions, queue-based scoreboard
// with a separate monitor that checks grants, latency and responses.
`default_nettype none

module tb_mul_share_arbiter;

  localparam int NREQ   = 4;
  localparam int SETTLE = 1;
  localparam int IDW    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        mul_a;
  logic [3:0]        mul_b;
  logic [7:0]        mul_res;
  logic              rsp_valid;
  logic [7:0]        rsp_res;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic              busy;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     res;
  } rsp_t;

  rsp_t            exp_rsp[$];
  logic [NREQ-1:0] exp_gnt[$];
  int              lat_q[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_gnt_cyc = -1;
  logic chk_interval = 1'b0;
  logic prev_valid   = 1'b0;

  always #5 clk = ~clk;

  // External multiplier model
  assign mul_res = 8'(mul_a) * 8'(mul_b);

  mul_share_arbiter #(
    .NREQ  (NREQ),
    .SETTLE(SETTLE),
    .IDW   (IDW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_res  (mul_res),
    .rsp_valid(rsp_valid),
    .rsp_res  (rsp_res),
    .rsp_id   (rsp_id),
    .rsp_ready(rsp_ready),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: grants, issue interval, grant-to-valid latency, responses
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      lat_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (req_ready != '0) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'd0);
        else chk("grant", 32'(req_ready), 32'(exp_gnt.pop_front()));
        if (chk_interval && last_gnt_cyc >= 0) chk("issue_interval", cyc - last_gnt_cyc, SETTLE + 2);
        last_gnt_cyc = cyc;
        lat_q.push_back(cyc);
      end
      if (rsp_valid && !prev_valid) begin
        if (lat_q.size() == 0) fail_now("rsp_without_grant");
        else chk("latency", cyc - lat_q.pop_front(), 1 + SETTLE);
      end
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_res", 32'(rsp_res), 32'(e.res));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic expect_txn(input logic [IDW-1:0] id, input logic [7:0] res);
    logic [NREQ-1:0] one;
    one = 1;
    exp_gnt.push_back(one << id);
    exp_rsp.push_back('{id: id, res: res});
  endtask

  // Waits for a transfer; returns the fired mask just after the accepting edge
  task automatic wait_grant(output logic [NREQ-1:0] g);
    logic done;
    done = 1'b0;
    g = '0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      g = req_ready & req_valid;
      @(posedge clk);
      #1;
      if (g != '0) done = 1'b1;
    end
    if (!done) fail_now("grant_timeout");
  endtask

  task automatic grant_and_drop();
    logic [NREQ-1:0] g;
    wait_grant(g);
    req_valid = req_valid & ~g;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!busy && exp_rsp.size() == 0) done = 1'b1;
    end
    if (!done) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic            seen;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with all four requesters already pending
    set_req(0, 4'd1, 4'd2);
    set_req(1, 4'd3, 4'd4);
    set_req(2, 4'd5, 4'd6);
    set_req(3, 4'd7, 4'd8);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_res",   32'(rsp_res),   32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_mul_a",     32'(mul_a),     32'd0);
    chk("rst_mul_b",     32'(mul_b),     32'd0);

    // All valid continuously: grants 0,1,2,3,0 every SETTLE+2 cycles
    expect_txn(2'd0, 8'd2);
    expect_txn(2'd1, 8'd12);
    expect_txn(2'd2, 8'd30);
    expect_txn(2'd3, 8'd56);
    expect_txn(2'd0, 8'd90);
    chk_interval = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      if (k == 0) set_req(0, 4'd9, 4'd10);
      if (k == 4) req_valid = '0;
    end
    wait_idle();
    chk_interval = 1'b0;

    // Single requester 2: 3*5
    expect_txn(2'd2, 8'd15);
    set_req(2, 4'd3, 4'd5);
    grant_and_drop();
    wait_idle();

    // rr_ptr now 3: req3 wins over req0, then wrap to req0
    expect_txn(2'd3, 8'd54);
    expect_txn(2'd0, 8'd14);
    set_req(0, 4'd2, 4'd7);
    set_req(3, 4'd6, 4'd9);
    grant_and_drop();
    grant_and_drop();
    wait_idle();

    // Operand extremes: 15*15 and 0*9
    expect_txn(2'd1, 8'd225);
    expect_txn(2'd2, 8'd0);
    set_req(1, 4'd15, 4'd15);
    set_req(2, 4'd0, 4'd9);
    grant_and_drop();
    grant_and_drop();
    wait_idle();

    // Response back-pressure: 11*13 held for 5 cycles while req1 waits
    expect_txn(2'd3, 8'd143);
    expect_txn(2'd1, 8'd16);
    rsp_ready = 1'b0;
    set_req(3, 4'd11, 4'd13);
    grant_and_drop();
    set_req(1, 4'd4, 4'd4);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) fail_now("stall_rsp_timeout");
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_res",   32'(rsp_res),   32'd143);
      chk("stall_rsp_id",    32'(rsp_id),    32'd3);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    grant_and_drop();
    wait_idle();

    // Reset while in MUL discards the operation and rr_ptr
    g = 4'b0010;
    exp_gnt.push_back(g);
    set_req(1, 4'd5, 4'd5);
    grant_and_drop();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    set_req(0, 4'd13, 4'd3);
    set_req(3, 4'd4, 4'd2);
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    expect_txn(2'd0, 8'd39);
    expect_txn(2'd3, 8'd8);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_and_drop();
    grant_and_drop();
    wait_idle();

    chk("leftover_rsp", exp_rsp.size(), 32'd0);
    chk("leftover_gnt", exp_gnt.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
